// File: rtl/mux4_rr_pkg.sv
// Shared types and defaults for the four-way round-robin burst mux.
package mux4_rr_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   typedef logic [1:0] owner_t;

   localparam int DEF_DW        = 8;
   localparam int DEF_MAX_BURST = 4;

   function automatic logic [3:0] onehot4(owner_t idx);
      logic [3:0] v;
      v = 4'b0000;
      v[idx] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/mux4_rr_sched_if.sv
// Requester/consumer bundle around mux4_rr_sched; master drives requests, slave is the scheduler.
interface mux4_rr_sched_if
   import mux4_rr_pkg::*;
#(
   parameter int DW = DEF_DW
);
   logic [3:0]    req;
   logic [DW-1:0] a;
   logic [DW-1:0] b;
   logic [DW-1:0] c;
   logic [DW-1:0] d;
   logic          y_ready;
   logic [3:0]    gnt;
   owner_t        sel;
   logic [DW-1:0] y;
   logic          y_valid;

   // Handshake: one transfer on every rising edge where y_valid && y_ready; y_ready is don't-care while y_valid is low.
   modport master (
      output req, a, b, c, d, y_ready,
      input  gnt, sel, y, y_valid
   );

   modport slave (
      input  req, a, b, c, d, y_ready,
      output gnt, sel, y, y_valid
   );
endinterface

// File: rtl/rr_pick4.sv
// Combinational round-robin pick: searches ptr+1, ptr+2, ptr+3, ptr (mod 4), first set req wins.
module rr_pick4
   import mux4_rr_pkg::*;
(
   input  logic [3:0] req,
   input  owner_t     ptr,
   output logic       found,
   output owner_t     idx
);

   owner_t cand;

   always_comb begin
      found = 1'b0;
      idx   = ptr;
      cand  = ptr;
      for (int k = 1; k <= 4; k++) begin
         cand = ptr + owner_t'(k);
         if (!found && req[cand]) begin
            found = 1'b1;
            idx   = cand;
         end
      end
   end

endmodule

// File: rtl/mux4_rr_sched.sv
// Four-input data mux whose select is owned by a round-robin arbiter granting bursts of up to MAX_BURST transfers.
module mux4_rr_sched
   import mux4_rr_pkg::*;
#(
   parameter int DW        = DEF_DW,
   parameter int MAX_BURST = DEF_MAX_BURST
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [3:0]    req,
   input  logic [DW-1:0] a,
   input  logic [DW-1:0] b,
   input  logic [DW-1:0] c,
   input  logic [DW-1:0] d,
   input  logic          y_ready,
   output logic [3:0]    gnt,
   output logic [1:0]    sel,
   output logic [DW-1:0] y,
   output logic          y_valid
);

   localparam int CW = $clog2(MAX_BURST + 1);

   state_t        state_q, state_d;
   logic [3:0]    gnt_q, gnt_d;
   owner_t        sel_q, sel_d;
   owner_t        last_q, last_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic   busy;
   logic   owner_req;
   logic   xfer;
   logic   last_beat;
   logic   release_now;
   owner_t pick_ptr;
   logic   pick_found;
   owner_t pick_idx;

   assign busy        = (state_q == BUSY);
   assign owner_req   = req[sel_q];
   assign y_valid     = busy && owner_req;
   assign xfer        = y_valid && y_ready;
   assign last_beat   = (cnt_q == CW'(MAX_BURST - 1));
   assign release_now = busy && (!owner_req || (xfer && last_beat));

   // On release the pointer used for the same-edge re-pick is the outgoing owner.
   assign pick_ptr = busy ? sel_q : last_q;

   rr_pick4 u_pick (
      .req   (req),
      .ptr   (pick_ptr),
      .found (pick_found),
      .idx   (pick_idx)
   );

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      sel_d   = sel_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      if (state_q == IDLE) begin
         if (pick_found) begin
            state_d = BUSY;
            gnt_d   = onehot4(pick_idx);
            sel_d   = pick_idx;
            cnt_d   = '0;
         end
      end else if (release_now) begin
         last_d = sel_q;
         cnt_d  = '0;
         if (pick_found) begin
            gnt_d = onehot4(pick_idx);
            sel_d = pick_idx;
         end else begin
            state_d = IDLE;
            gnt_d   = 4'b0000;
            sel_d   = '0;
         end
      end else if (xfer) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         gnt_q   <= 4'b0000;
         sel_q   <= '0;
         last_q  <= 2'd3;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         sel_q   <= sel_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      y = '0;
      if (busy) begin
         case (sel_q)
            2'd0:    y = a;
            2'd1:    y = b;
            2'd2:    y = c;
            default: y = d;
         endcase
      end
   end

   assign gnt = gnt_q;
   assign sel = sel_q;

endmodule

// File: tb/tb_mux4_rr_sched.sv
// Bench for mux4_rr_sched: directed scenarios plus random traffic against a burst-level arbitration model.
module tb_mux4_rr_sched;

   localparam int DW = 8;
   localparam int MB = 4;

   logic clk;
   logic rst_n;
   int   n_assert;
   int   n_fail;

   // Reference model: owner index (-1 none), beats taken in current burst, last released owner.
   int   m_owner;
   int   m_beats;
   int   m_last;

   mux4_rr_sched_if #(.DW(DW)) bus ();
   mux4_rr_sched_if #(.DW(DW)) bus1 ();

   mux4_rr_sched #(.DW(DW), .MAX_BURST(MB)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (bus.req),
      .a       (bus.a),
      .b       (bus.b),
      .c       (bus.c),
      .d       (bus.d),
      .y_ready (bus.y_ready),
      .gnt     (bus.gnt),
      .sel     (bus.sel),
      .y       (bus.y),
      .y_valid (bus.y_valid)
   );

   mux4_rr_sched #(.DW(DW), .MAX_BURST(1)) dut1 (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (bus1.req),
      .a       (bus1.a),
      .b       (bus1.b),
      .c       (bus1.c),
      .d       (bus1.d),
      .y_ready (bus1.y_ready),
      .gnt     (bus1.gnt),
      .sel     (bus1.sel),
      .y       (bus1.y),
      .y_valid (bus1.y_valid)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int rr_next(int last, logic [3:0] r);
      for (int k = 1; k <= 4; k++) begin
         if (r[(last + k) % 4]) return (last + k) % 4;
      end
      return -1;
   endfunction

   function automatic logic [DW-1:0] data_of(int i);
      case (i)
         0:       return bus.a;
         1:       return bus.b;
         2:       return bus.c;
         default: return bus.d;
      endcase
   endfunction

   task automatic model_reset();
      m_owner = -1;
      m_beats = 0;
      m_last  = 3;
   endtask

   // One rising edge of the reference arbiter, using the inputs held across that edge.
   task automatic model_step();
      if (m_owner < 0) begin
         m_owner = rr_next(m_last, bus.req);
         m_beats = 0;
      end else begin
         if (bus.req[m_owner] && bus.y_ready) m_beats++;
         if (!bus.req[m_owner] || m_beats == MB) begin
            m_last  = m_owner;
            m_owner = rr_next(m_last, bus.req);
            m_beats = 0;
         end
      end
   endtask

   task automatic check_model();
      logic [3:0]    e_gnt;
      logic [1:0]    e_sel;
      logic          e_vld;
      logic [DW-1:0] e_y;
      e_gnt = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
      e_sel = (m_owner < 0) ? 2'd0 : 2'(m_owner);
      e_vld = (m_owner >= 0) && bus.req[e_sel];
      e_y   = (m_owner < 0) ? '0 : data_of(m_owner);
      check("gnt", 32'(bus.gnt), 32'(e_gnt));
      check("sel", 32'(bus.sel), 32'(e_sel));
      check("y_valid", 32'(bus.y_valid), 32'(e_vld));
      check("y", 32'(bus.y), 32'(e_y));
   endtask

   // Called at a falling edge with inputs already applied; returns at the next falling edge.
   task automatic tick();
      #1;
      check_model();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n        = 1'b0;
      bus.req      = 4'b0000;
      bus.y_ready  = 1'b0;
      bus1.req     = 4'b0000;
      bus1.y_ready = 1'b0;
      model_reset();
      #1;
      check("rst_gnt", 32'(bus.gnt), 32'h0);
      check("rst_sel", 32'(bus.sel), 32'h0);
      check("rst_valid", 32'(bus.y_valid), 32'h0);
      check("rst_y", 32'(bus.y), 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic rand_data();
      bus.a = 8'($urandom);
      bus.b = 8'($urandom);
      bus.c = 8'($urandom);
      bus.d = 8'($urandom);
   endtask

   initial begin
      n_assert = 0;
      n_fail   = 0;
      rst_n    = 1'b0;
      bus.req = 4'b0000; bus.y_ready = 1'b0;
      bus.a = 8'hA0; bus.b = 8'hB1; bus.c = 8'hC2; bus.d = 8'hD3;
      bus1.req = 4'b0000; bus1.y_ready = 1'b0;
      bus1.a = 8'h11; bus1.b = 8'h22; bus1.c = 8'h33; bus1.d = 8'h44;
      model_reset();
      @(negedge clk);
      do_reset();

      // Single requester a: grant after one edge, 4 beats, then immediate re-grant to a.
      rand_data();
      bus.req = 4'b0001; bus.y_ready = 1'b1;
      #1;
      check("a_pre_gnt", 32'(bus.gnt), 32'h0);
      tick();
      for (int i = 0; i < 9; i++) begin
         #1;
         check("a_gnt", 32'(bus.gnt), 32'h1);
         check("a_y", 32'(bus.y), 32'(bus.a));
         tick();
      end

      // All four requesting: a,b,c,d,a with exactly four valid cycles each, no gaps.
      do_reset();
      bus.req = 4'b1111; bus.y_ready = 1'b1;
      tick();
      for (int k = 0; k < 20; k++) begin
         #1;
         check("rr_gnt", 32'(bus.gnt), 32'(1 << ((k / 4) % 4)));
         check("rr_valid", 32'(bus.y_valid), 32'h1);
         tick();
      end

      // Stalled consumer holds a's grant; beats only count once y_ready returns.
      do_reset();
      bus.req = 4'b0001; bus.y_ready = 1'b0;
      tick();
      for (int i = 0; i < 10; i++) begin
         #1;
         check("stall_gnt", 32'(bus.gnt), 32'h1);
         check("stall_valid", 32'(bus.y_valid), 32'h1);
         tick();
      end
      bus.req = 4'b0011; bus.y_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         check("stall_burst_gnt", 32'(bus.gnt), 32'h1);
         tick();
      end
      #1;
      check("stall_next_gnt", 32'(bus.gnt), 32'h2);

      // b drops its request after two beats; same-edge re-grant searches c,d,a and finds d.
      do_reset();
      bus.req = 4'b0010; bus.y_ready = 1'b1;
      tick();
      tick();
      tick();
      bus.req = 4'b1001;
      #1;
      check("drop_gnt_b", 32'(bus.gnt), 32'h2);
      check("drop_valid", 32'(bus.y_valid), 32'h0);
      tick();
      #1;
      check("drop_gnt_d", 32'(bus.gnt), 32'h8);
      check("drop_sel_d", 32'(bus.sel), 32'h3);

      // Asynchronous reset in the middle of a burst, then c is first after release.
      do_reset();
      bus.req = 4'b1111; bus.y_ready = 1'b1;
      for (int i = 0; i < 6; i++) tick();
      check("async_pre", 32'(bus.gnt != 4'b0000), 32'h1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_gnt", 32'(bus.gnt), 32'h0);
      check("async_valid", 32'(bus.y_valid), 32'h0);
      check("async_sel", 32'(bus.sel), 32'h0);
      model_reset();
      bus.req = 4'b0100;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      #1;
      check("async_gnt_c", 32'(bus.gnt), 32'h4);
      check("async_sel_c", 32'(bus.sel), 32'h2);

      // Random traffic against the model.
      do_reset();
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) == 0) bus.req = 4'($urandom_range(0, 15));
         bus.y_ready = ($urandom_range(0, 3) != 0);
         rand_data();
         tick();
      end

      // MAX_BURST=1: a and b alternate every cycle.
      do_reset();
      bus1.req = 4'b0011; bus1.y_ready = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 8; k++) begin
         #1;
         check("mb1_gnt", 32'(bus1.gnt), 32'(1 << (k % 2)));
         check("mb1_valid", 32'(bus1.y_valid), 32'h1);
         @(negedge clk);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
